// File: rtl/instr_enc_pkg.sv
// rtl/instr_enc_pkg.sv - op kind codes and MIPS opcode/funct constants shared by encoder and decoder
package instr_enc_pkg;

  localparam logic [4:0] OPK_NOP    = 5'd0;
  localparam logic [4:0] OPK_ADDU   = 5'd1;
  localparam logic [4:0] OPK_SUBU   = 5'd2;
  localparam logic [4:0] OPK_JR     = 5'd3;
  localparam logic [4:0] OPK_ORI    = 5'd4;
  localparam logic [4:0] OPK_LUI    = 5'd5;
  localparam logic [4:0] OPK_LW     = 5'd6;
  localparam logic [4:0] OPK_LH     = 5'd7;
  localparam logic [4:0] OPK_LB     = 5'd8;
  localparam logic [4:0] OPK_SW     = 5'd9;
  localparam logic [4:0] OPK_SH     = 5'd10;
  localparam logic [4:0] OPK_SB     = 5'd11;
  localparam logic [4:0] OPK_BEQ    = 5'd12;
  localparam logic [4:0] OPK_BLTZAL = 5'd13;
  localparam logic [4:0] OPK_J      = 5'd14;
  localparam logic [4:0] OPK_JAL    = 5'd15;
  localparam logic [4:0] OPK_LI     = 5'd16;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;

  localparam logic [4:0] RT_BLTZAL  = 5'b10000;

  typedef enum logic {ST_IDLE, ST_LI2} enc_state_t;

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// rtl/instr_field_pack.sv - combinational op kind + fields to machine word, with range and legality flags
module instr_field_pack
  import instr_enc_pkg::*;
(
  input  logic [4:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_err,
  output logic        legal
);

  logic simm_ok;
  logic uimm_ok;
  logic align_ok;

  // Signed 16-bit fields require bits 31..15 to be a pure sign extension.
  assign simm_ok  = (imm[31:15] == 17'h00000) || (imm[31:15] == 17'h1FFFF);
  assign uimm_ok  = (imm[31:16] == 16'h0000);
  assign align_ok = (imm[1:0] == 2'b00);

  always_comb begin
    word      = 32'h0;
    range_err = 1'b0;
    legal     = 1'b1;
    case (kind)
      OPK_NOP:    word = 32'h0;
      OPK_ADDU:   word = {OP_SPECIAL, rs, rt, rd, 5'd0, FN_ADDU};
      OPK_SUBU:   word = {OP_SPECIAL, rs, rt, rd, 5'd0, FN_SUBU};
      OPK_JR:     word = {OP_SPECIAL, rs, 15'd0, FN_JR};
      OPK_ORI: begin
        word      = i_word(OP_ORI, rs, rt, imm[15:0]);
        range_err = !uimm_ok;
      end
      OPK_LUI: begin
        word      = i_word(OP_LUI, 5'd0, rt, imm[15:0]);
        range_err = !uimm_ok;
      end
      OPK_LW: begin
        word      = i_word(OP_LW, rs, rt, imm[15:0]);
        range_err = !simm_ok;
      end
      OPK_LH: begin
        word      = i_word(OP_LH, rs, rt, imm[15:0]);
        range_err = !simm_ok;
      end
      OPK_LB: begin
        word      = i_word(OP_LB, rs, rt, imm[15:0]);
        range_err = !simm_ok;
      end
      OPK_SW: begin
        word      = i_word(OP_SW, rs, rt, imm[15:0]);
        range_err = !simm_ok;
      end
      OPK_SH: begin
        word      = i_word(OP_SH, rs, rt, imm[15:0]);
        range_err = !simm_ok;
      end
      OPK_SB: begin
        word      = i_word(OP_SB, rs, rt, imm[15:0]);
        range_err = !simm_ok;
      end
      OPK_BEQ: begin
        word      = i_word(OP_BEQ, rs, rt, imm[15:0]);
        range_err = !simm_ok;
      end
      OPK_BLTZAL: begin
        word      = i_word(OP_REGIMM, rs, RT_BLTZAL, imm[15:0]);
        range_err = !simm_ok;
      end
      OPK_J: begin
        word      = {OP_J, imm[27:2]};
        range_err = !align_ok;
      end
      OPK_JAL: begin
        word      = {OP_JAL, imm[27:2]};
        range_err = !align_ok;
      end
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streams symbolic ops as MIPS words to an IM write port, expanding LI
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [4:0]       op_kind,
  input  logic [4:0]       op_rs,
  input  logic [4:0]       op_rt,
  input  logic [4:0]       op_rd,
  input  logic [31:0]      op_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_addr,
  output logic             err,
  output logic [CNT_W-1:0] word_cnt
);

  enc_state_t  state;
  logic [31:0] pend_instr;

  logic        is_li;
  logic        li_lo_only;
  logic        li_split;
  logic [31:0] li_second;
  logic [4:0]  pk_kind;
  logic [4:0]  pk_rs;
  logic [31:0] pk_imm;
  logic [31:0] pk_word;
  logic        range_err;
  logic        legal;
  logic        accept;
  logic        out_hs;

  // LI is rewritten into the ORI or LUI form before packing; a split LI parks its ORI half.
  assign is_li      = (op_kind == OPK_LI);
  assign li_lo_only = (op_imm[31:16] == 16'h0000);
  assign li_split   = is_li && !li_lo_only && (op_imm[15:0] != 16'h0000);
  assign li_second  = i_word(OP_ORI, op_rt, op_rt, op_imm[15:0]);

  assign pk_kind = !is_li ? op_kind : (li_lo_only ? OPK_ORI : OPK_LUI);
  assign pk_rs   = is_li ? 5'd0 : op_rs;
  assign pk_imm  = !is_li ? op_imm
                 : (li_lo_only ? {16'h0000, op_imm[15:0]} : {16'h0000, op_imm[31:16]});

  instr_field_pack u_pack (
    .kind      (pk_kind),
    .rs        (pk_rs),
    .rt        (op_rt),
    .rd        (op_rd),
    .imm       (pk_imm),
    .word      (pk_word),
    .range_err (range_err),
    .legal     (legal)
  );

  assign op_ready = reset_n && (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = op_valid && op_ready;
  assign out_hs   = out_valid && out_ready;
  assign out_addr = BASE_ADDR + 32'({word_cnt, 2'b00});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_instr  <= 32'h0;
      pend_instr <= 32'h0;
      err        <= 1'b0;
      word_cnt   <= '0;
    end else begin
      err <= 1'b0;
      if (out_hs) word_cnt <= word_cnt + CNT_W'(1);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            err       <= range_err || !legal;
            out_valid <= legal;
            if (legal) out_instr <= pk_word;
            if (li_split) begin
              pend_instr <= li_second;
              state      <= ST_LI2;
            end
          end else if (out_hs) begin
            out_valid <= 1'b0;
          end
        end
        ST_LI2: begin
          // First LI word stays on the port until the sink takes it.
          if (out_hs) begin
            out_instr <= pend_instr;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder with directed and randomized ops
module tb_instr_encoder;
  import instr_enc_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [4:0]  op_kind = 5'd0;
  logic [4:0]  op_rs = 5'd0;
  logic [4:0]  op_rt = 5'd0;
  logic [4:0]  op_rd = 5'd0;
  logic [31:0] op_imm = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic [15:0] word_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] obs_q[$];
  int  err_seen = 0;
  bit  rnd_ready = 1'b0;
  bit  ready_hold = 1'b1;

  instr_encoder #(.BASE_ADDR(32'h0000_3000), .CNT_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_kind   (op_kind),
    .op_rs     (op_rs),
    .op_rt     (op_rt),
    .op_rd     (op_rd),
    .op_imm    (op_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_hold;
  end

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) obs_q.push_back({out_addr, out_instr});
    if (err) err_seen++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
    obs_q.delete();
    err_seen = 0;
  endtask

  task automatic send_op(input logic [4:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] imm);
    int n = 0;
    op_kind = k; op_rs = rs; op_rt = rt; op_rd = rd; op_imm = imm;
    op_valid = 1'b1;
    @(negedge clk);
    while (!op_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!op_ready) begin
      miscompares++;
      $display("FAIL op_accept_timeout: op_ready=%0b required 1", op_ready);
    end
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  task automatic wait_drain(input int n);
    int c = 0;
    while (obs_q.size() < n && c < 3000) begin
      @(negedge clk);
      c++;
    end
    idle(4);
  endtask

  // Reference encoder written from the ISA rules with plain arithmetic.
  function automatic void model(input logic [4:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [31:0] imm, output int n,
                                output logic [31:0] w0, output logic [31:0] w1, output bit e);
    longint s;
    bit sbad, ubad;
    logic [31:0] lo, hi, r;
    int opc;
    s    = longint'($signed(imm));
    sbad = (s < -32768) || (s > 32767);
    ubad = imm > 32'h0000_FFFF;
    lo   = imm & 32'h0000_FFFF;
    hi   = imm >> 16;
    r    = (32'(rs) << 21) | (32'(rt) << 16);
    n = 1; w0 = 32'h0; w1 = 32'h0; e = 1'b0; opc = -1;
    case (k)
      OPK_NOP:    w0 = 32'h0;
      OPK_ADDU:   w0 = r | (32'(rd) << 11) | 32'd33;
      OPK_SUBU:   w0 = r | (32'(rd) << 11) | 32'd35;
      OPK_JR:     w0 = (32'(rs) << 21) | 32'd8;
      OPK_ORI:    begin w0 = (32'd13 << 26) | r | lo; e = ubad; end
      OPK_LUI:    begin w0 = (32'd15 << 26) | (32'(rt) << 16) | lo; e = ubad; end
      OPK_LW:     opc = 35;
      OPK_LH:     opc = 33;
      OPK_LB:     opc = 32;
      OPK_SW:     opc = 43;
      OPK_SH:     opc = 41;
      OPK_SB:     opc = 40;
      OPK_BEQ:    opc = 4;
      OPK_BLTZAL: begin w0 = (32'd1 << 26) | (32'(rs) << 21) | (32'd16 << 16) | lo; e = sbad; end
      OPK_J:      begin w0 = (32'd2 << 26) | ((imm >> 2) & 32'h03FF_FFFF); e = (imm % 4) != 0; end
      OPK_JAL:    begin w0 = (32'd3 << 26) | ((imm >> 2) & 32'h03FF_FFFF); e = (imm % 4) != 0; end
      OPK_LI: begin
        if (hi == 0) w0 = (32'd13 << 26) | (32'(rt) << 16) | lo;
        else if (lo == 0) w0 = (32'd15 << 26) | (32'(rt) << 16) | hi;
        else begin
          n  = 2;
          w0 = (32'd15 << 26) | (32'(rt) << 16) | hi;
          w1 = (32'd13 << 26) | (32'(rt) << 21) | (32'(rt) << 16) | lo;
        end
      end
      default: begin n = 0; e = 1'b1; end
    endcase
    if (opc >= 0) begin
      w0 = (32'(opc) << 26) | r | lo;
      e  = sbad;
    end
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    vectors++;
    if (out_valid !== 1'b0 || err !== 1'b0 || op_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: valid=%b err=%b op_ready=%b required 0 0 0", out_valid, err, op_ready);
    end
    vectors++;
    if (word_cnt !== 16'h0 || out_instr !== 32'h0 || out_addr !== 32'h3000) begin
      miscompares++;
      $display("FAIL reset_data: cnt=%h instr=%h addr=%h required 0000 00000000 00003000",
               word_cnt, out_instr, out_addr);
    end
  endtask

  task automatic test_directed();
    logic [63:0] exp_w[6];
    exp_w = '{{32'h3000, 32'h00221821}, {32'h3004, 32'h3C081234}, {32'h3008, 32'h35085678},
              {32'h300C, 32'h8FA4FFFC}, {32'h3010, 32'h34010000}, {32'h3014, 32'h04B00003}};
    ready_hold = 1'b1;
    do_reset();
    send_op(OPK_ADDU, 5'd1, 5'd2, 5'd3, 32'h0);
    send_op(OPK_LI, 5'd0, 5'd8, 5'd0, 32'h1234_5678);
    @(negedge clk);
    vectors++;
    if (op_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL li_op_ready: got %b required 0", op_ready);
    end
    send_op(OPK_LW, 5'd29, 5'd4, 5'd0, 32'hFFFF_FFFC);
    send_op(OPK_ORI, 5'd0, 5'd1, 5'd0, 32'h0001_0000);
    send_op(OPK_BLTZAL, 5'd5, 5'd0, 5'd0, 32'd3);
    send_op(5'd31, 5'd0, 5'd0, 5'd0, 32'h0);
    wait_drain(6);
    vectors++;
    if (obs_q.size() != 6) begin
      miscompares++;
      $display("FAIL dir_count: got %0d words required 6", obs_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (i >= obs_q.size() || obs_q[i] !== exp_w[i]) begin
        miscompares++;
        $display("FAIL dir_word%0d: got %h required %h", i,
                 (i < obs_q.size()) ? obs_q[i] : 64'h0, exp_w[i]);
      end
    end
    vectors++;
    if (err_seen != 2 || word_cnt !== 16'd6) begin
      miscompares++;
      $display("FAIL dir_err_cnt: err=%0d cnt=%0d required 2 6", err_seen, word_cnt);
    end
  endtask

  task automatic test_li_stall();
    ready_hold = 1'b0;
    do_reset();
    idle(1);
    send_op(OPK_LI, 5'd0, 5'd8, 5'd0, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_instr !== 32'h3C081234 || out_addr !== 32'h3000 || op_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL li_stall%0d: v=%b instr=%h addr=%h rdy=%b required 1 3c081234 00003000 0",
                 i, out_valid, out_instr, out_addr, op_ready);
      end
    end
    ready_hold = 1'b1;
    wait_drain(2);
    vectors++;
    if (obs_q.size() != 2 || obs_q[0] !== {32'h3000, 32'h3C081234} || obs_q[1] !== {32'h3004, 32'h35085678}) begin
      miscompares++;
      $display("FAIL li_release: got %0d words first=%h required 2 words in order",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'h0);
    end
  endtask

  task automatic test_reset_mid_li();
    ready_hold = 1'b1;
    do_reset();
    send_op(OPK_ADDU, 5'd1, 5'd2, 5'd3, 32'h0);
    wait_drain(1);
    vectors++;
    if (word_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL pre_reset_cnt: got %0d required 1", word_cnt);
    end
    ready_hold = 1'b0;
    idle(2);
    send_op(OPK_LI, 5'd0, 5'd9, 5'd0, 32'hABCD_0123);
    idle(2);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || word_cnt !== 16'd0 || op_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_li_reset: v=%b cnt=%0d rdy=%b required 0 0 0", out_valid, word_cnt, op_ready);
    end
    idle(2);
    ready_hold = 1'b1;
    reset_n = 1'b1;
    idle(3);
    obs_q.delete();
    err_seen = 0;
    send_op(OPK_ADDU, 5'd1, 5'd2, 5'd3, 32'h0);
    wait_drain(1);
    vectors++;
    if (obs_q.size() != 1 || obs_q[0] !== {32'h3000, 32'h00221821}) begin
      miscompares++;
      $display("FAIL post_reset_op: got %0d words first=%h required 1 word 0000300000221821",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'h0);
    end
  endtask

  task automatic test_random();
    logic [63:0] exp_q[$];
    int exp_cnt = 0, exp_err = 0, n;
    logic [31:0] w0, w1, imm;
    logic [4:0] k, rs, rt, rd;
    bit e;
    ready_hold = 1'b1;
    do_reset();
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      k  = 5'($urandom_range(0, 20));
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      case ($urandom_range(0, 4))
        0: imm = 32'($urandom_range(0, 65535));
        1: imm = 32'($urandom_range(0, 65535)) - 32'd32768;
        2: imm = $urandom;
        3: imm = {16'($urandom_range(0, 65535)), 16'h0000};
        default: imm = $urandom & 32'hFFFF_FFFC;
      endcase
      model(k, rs, rt, rd, imm, n, w0, w1, e);
      if (n >= 1) begin exp_q.push_back({32'h3000 + 32'(exp_cnt * 4), w0}); exp_cnt++; end
      if (n == 2) begin exp_q.push_back({32'h3000 + 32'(exp_cnt * 4), w1}); exp_cnt++; end
      if (e) exp_err++;
      send_op(k, rs, rt, rd, imm);
    end
    wait_drain(exp_cnt);
    rnd_ready = 1'b0;
    idle(4);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL rnd_count: got %0d words required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL rnd_word%0d: got %h required %h", i,
                 (i < obs_q.size()) ? obs_q[i] : 64'h0, exp_q[i]);
      end
    end
    vectors++;
    if (err_seen != exp_err) begin
      miscompares++;
      $display("FAIL rnd_err: got %0d pulses required %0d", err_seen, exp_err);
    end
    vectors++;
    if (word_cnt !== 16'(exp_cnt)) begin
      miscompares++;
      $display("FAIL rnd_word_cnt: got %0d required %0d", word_cnt, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_li_stall();
    test_reset_mid_li();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
